// File: rtl/sel_slot_buf.sv
// sel_slot_buf
// Entry buffer that sits directly in front of the priority selector. It keeps
// up to IN elements in fixed slots. The slot contents and an active-high
// occupancy bitmap feed the selector. The selector's one-hot pos result
// returns as a grant, and the granted slot is freed.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   clr        synchronous flush of every slot (wins over write and release)
//   we/wdata   write request and data
//   wready     a write can be accepted this cycle (decoded from cnt only)
//   wslot      one-hot slot a write this cycle lands in (lowest free, 0 when full)
//   req        occupancy bitmap, bit k = slot k valid
//   ent        packed slot contents, slot k at index k
//   gnt_valid  grant qualifier
//   gnt        one-hot grant from the selector
//   count      number of occupied slots
//   empty/full count == 0 / count == IN
module sel_slot_buf #(
    parameter int DATA = 5,
    parameter int IN   = 8,
    parameter int CNTW = $clog2(IN + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      we,
    input  logic [DATA-1:0]           wdata,
    output logic                      wready,
    output logic [IN-1:0]             wslot,
    output logic [IN-1:0]             req,
    output logic [IN-1:0][DATA-1:0]   ent,
    input  logic                      gnt_valid,
    input  logic [IN-1:0]             gnt,
    output logic [CNTW-1:0]           count,
    output logic                      empty,
    output logic                      full
);

    logic [IN-1:0]            vld;
    logic [IN-1:0][DATA-1:0]  dat;
    logic [CNTW-1:0]          cnt;

    logic                     wacc;
    logic [IN-1:0]            rel;
    logic [IN-1:0]            rel_lo;
    logic                     rel_any;

    assign req   = vld;
    assign ent   = dat;
    assign count = cnt;

    // Status comes from the counter register alone, so a grant in a full
    // cycle does not open wready until the following cycle.
    assign empty  = (cnt == '0);
    assign full   = (cnt == CNTW'(IN));
    assign wready = !full;

    // Lowest-index free slot. Scanning downward lets the lowest free slot win.
    always_comb begin
        wslot = '0;
        for (int k = IN - 1; k >= 0; k--) begin
            if (!vld[k]) begin
                wslot    = '0;
                wslot[k] = 1'b1;
            end
        end
    end

    assign wacc = we && wready;

    // Grant bits on empty slots are ignored. If an illegal multi-bit grant
    // arrives, only its lowest bit is honoured.
    assign rel     = gnt_valid ? (gnt & vld) : '0;
    assign rel_lo  = rel & (~rel + IN'(1));
    assign rel_any = (rel != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            dat <= '0;
            cnt <= '0;
        end else if (clr) begin
            vld <= '0;
            cnt <= '0;
        end else begin
            // The write slot is free and the released slot is occupied, so
            // these two updates never touch the same slot.
            for (int k = 0; k < IN; k++) begin
                if (wacc && wslot[k]) begin
                    dat[k] <= wdata;
                end
            end
            vld <= (vld | (wacc ? wslot : '0)) & ~rel_lo;
            cnt <= cnt + CNTW'(wacc) - CNTW'(rel_any);
        end
    end

    a_cnt_matches_vld : assert property (@(posedge clk) disable iff (reset)
        int'(cnt) == $countones(vld));

    a_no_write_when_full : assert property (@(posedge clk) disable iff (reset)
        !wready |=> (cnt <= $past(cnt)));

    a_gnt_onehot : assert property (@(posedge clk) disable iff (reset)
        gnt_valid |-> $onehot0(gnt));

endmodule

// File: tb/tb_sel_slot_buf.sv
// Testbench for sel_slot_buf (IN=4, DATA=5). It runs directed scenarios and
// then randomized traffic. Every cycle is checked against a slot-array model.
module tb_sel_slot_buf;

    localparam int DATA = 5;
    localparam int IN   = 4;
    localparam int CNTW = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    clr;
    logic                    we;
    logic [DATA-1:0]         wdata;
    logic                    wready;
    logic [IN-1:0]           wslot;
    logic [IN-1:0]           req;
    logic [IN-1:0][DATA-1:0] ent;
    logic                    gnt_valid;
    logic [IN-1:0]           gnt;
    logic [CNTW-1:0]         count;
    logic                    empty;
    logic                    full;

    sel_slot_buf #(.DATA(DATA), .IN(IN), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .we        (we),
        .wdata     (wdata),
        .wready    (wready),
        .wslot     (wslot),
        .req       (req),
        .ent       (ent),
        .gnt_valid (gnt_valid),
        .gnt       (gnt),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit              m_vld [IN];
    logic [DATA-1:0] m_dat [IN];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < IN; i++) if (m_vld[i]) c++;
        return c;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < IN; i++) if (!m_vld[i]) return i;
        return -1;
    endfunction

    function automatic logic [IN-1:0] m_req();
        logic [IN-1:0] r = '0;
        for (int i = 0; i < IN; i++) r[i] = m_vld[i];
        return r;
    endfunction

    function automatic logic [IN-1:0] m_wslot();
        logic [IN-1:0] r = '0;
        int f = m_first_free();
        if (f >= 0) r[f] = 1'b1;
        return r;
    endfunction

    function automatic logic [IN*DATA-1:0] m_ent();
        logic [IN*DATA-1:0] r = '0;
        for (int i = 0; i < IN; i++) r[i*DATA +: DATA] = m_dat[i];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < IN; i++) begin
            m_vld[i] = 1'b0;
            m_dat[i] = '0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".req"},    req,    m_req());
        check({tag, ".ent"},    ent,    m_ent());
        check({tag, ".count"},  count,  m_count());
        check({tag, ".empty"},  empty,  m_count() == 0);
        check({tag, ".full"},   full,   m_count() == IN);
        check({tag, ".wready"}, wready, m_count() != IN);
        check({tag, ".wslot"},  wslot,  m_wslot());
    endtask

    // Drive one cycle of inputs, update the model at the edge, and check at
    // the following falling edge.
    task automatic step(input string tag, input logic w, input logic [DATA-1:0] d,
                        input logic gv, input logic [IN-1:0] g, input logic c);
        int rel;
        int slot;
        bit can_write;
        we = w; wdata = d; gnt_valid = gv; gnt = g; clr = c;
        #1;
        check({tag, ".pre_wslot"}, wslot, m_wslot());
        @(posedge clk);
        if (c) begin
            for (int i = 0; i < IN; i++) m_vld[i] = 1'b0;
        end else begin
            rel = -1;
            if (gv) begin
                for (int i = 0; i < IN; i++) begin
                    if (g[i] && m_vld[i]) begin
                        rel = i;
                        break;
                    end
                end
            end
            can_write = w && (m_count() < IN);
            if (can_write) begin
                slot = m_first_free();
                m_dat[slot] = d;
                m_vld[slot] = 1'b1;
            end
            if (rel >= 0) m_vld[rel] = 1'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic [IN-1:0] g;
        reset = 1'b1; clr = 1'b0; we = 1'b0; wdata = '0; gnt_valid = 1'b0; gnt = '0;
        m_reset();
        #1;
        check_outputs("reset");
        check("reset.wslot_const", wslot, 4'b0001);
        @(negedge clk);
        reset = 1'b0;

        // Fill all four slots in order.
        for (int i = 0; i < IN; i++) step("fill", 1'b1, DATA'(i + 1), 1'b0, '0, 1'b0);
        check("fill.ent_const", ent, 20'h20C41);
        check("fill.full_const", full, 1'b1);

        step("drop_when_full", 1'b1, 5'h1F, 1'b0, '0, 1'b0);
        check("drop.count_const", count, 3'd4);

        step("grant_slot2", 1'b0, '0, 1'b1, 4'b0100, 1'b0);
        check("grant_slot2.req_const", req, 4'b1011);
        step("refill_slot2", 1'b1, 5'h0A, 1'b0, '0, 1'b0);
        check("refill.ent2", ent[2], 5'h0A);

        step("rel3", 1'b0, '0, 1'b1, 4'b1000, 1'b0);
        step("rel2", 1'b0, '0, 1'b1, 4'b0100, 1'b0);
        step("wr_and_rel", 1'b1, 5'h07, 1'b1, 4'b0001, 1'b0);
        check("wr_and_rel.req_const", req, 4'b0110);
        check("wr_and_rel.ent2", ent[2], 5'h07);

        step("flush", 1'b0, '0, 1'b0, '0, 1'b1);
        step("one_entry", 1'b1, 5'h11, 1'b0, '0, 1'b0);
        step("gnt_empty_slot", 1'b0, '0, 1'b1, 4'b0100, 1'b0);
        step("gnt_unqualified", 1'b0, '0, 1'b0, 4'b0001, 1'b0);
        check("gnt_ignored.count_const", count, 3'd1);

        step("w2", 1'b1, 5'h12, 1'b0, '0, 1'b0);
        step("w3", 1'b1, 5'h13, 1'b0, '0, 1'b0);
        step("clr_over_write", 1'b1, 5'h1E, 1'b0, '0, 1'b1);
        check("clr.empty_const", empty, 1'b1);

        // Randomized traffic with legal (one-hot or zero) grants.
        for (int n = 0; n < 400; n++) begin
            g = '0;
            if ($urandom_range(0, 4) != 0) g[$urandom_range(0, IN - 1)] = 1'b1;
            step("rand", 1'($urandom_range(0, 2) != 0), DATA'($urandom),
                 1'($urandom_range(0, 1)), g, 1'($urandom_range(0, 24) == 0));
        end

        // Asynchronous reset in the middle of traffic with two entries held.
        step("pre_rst_clr", 1'b0, '0, 1'b0, '0, 1'b1);
        step("pre_rst_w1", 1'b1, 5'h05, 1'b0, '0, 1'b0);
        step("pre_rst_w2", 1'b1, 5'h06, 1'b0, '0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        check_outputs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            g = '0;
            if ($urandom_range(0, 3) != 0) g[$urandom_range(0, IN - 1)] = 1'b1;
            step("post_rst", 1'($urandom_range(0, 1)), DATA'($urandom),
                 1'($urandom_range(0, 1)), g, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
